// File: rtl/lcd_refresh.sv
// HD44780-style 4-bit LCD refresher: power-up, init and config, then an endless
// scan of a 32x8 character RAM onto two 16-character lines.
//
// top state | meaning
// PWRUP     | wait T_PWRUP cycles, all LCD outputs low
// INIT      | four single init nibbles 3,3,3,2 with their own waits
// CFG       | command bytes 0x28, 0x06, 0x0C, 0x01
// ADDR      | DDRAM address command (0x80 line 1, 0xC0 line 2)
// CHAR      | one character byte from RAM[radd], rs=1
//
// nibble state | meaning
// IDLE         | waiting for a job (one cycle between jobs)
// SETUP        | data/rs presented, lcd_e low
// EHI          | lcd_e high for E_CYC cycles
// HOLD         | lcd_e low, data held
// GAP          | post-nibble wait; GAP plus the following IDLE form the wait
module lcd_refresh #(
   parameter int T_PWRUP = 750000,
   parameter int T_LONG  = 205000,
   parameter int T_SHORT = 5000,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000,
   parameter int E_CYC   = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [4:0] radd,
   input  logic [7:0] dout,
   output logic [3:0] lcd_d,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       ready,
   output logic       frame
);

   localparam int M1 = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
   localparam int M2 = (M1 > T_SHORT) ? M1 : T_SHORT;
   localparam int M3 = (M2 > T_CMD) ? M2 : T_CMD;
   localparam int M4 = (M3 > T_CLR) ? M3 : T_CLR;
   localparam int M5 = (M4 > E_CYC) ? M4 : E_CYC;
   localparam int CW = $clog2(M5 + 1);

   localparam logic [2:0] S_PWRUP = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_CFG   = 3'd2;
   localparam logic [2:0] S_ADDR  = 3'd3;
   localparam logic [2:0] S_CHAR  = 3'd4;

   localparam logic [2:0] N_IDLE  = 3'd0;
   localparam logic [2:0] N_SETUP = 3'd1;
   localparam logic [2:0] N_EHI   = 3'd2;
   localparam logic [2:0] N_HOLD  = 3'd3;
   localparam logic [2:0] N_GAP   = 3'd4;

   logic [2:0]    st_q, st_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          lo_q, lo_d;
   logic [7:0]    char_q, char_d;
   logic [4:0]    radd_q, radd_d;
   logic          ready_q, ready_d;
   logic          frame_q, frame_d;

   logic [2:0]    nst_q, nst_d;
   logic [CW-1:0] ncnt_q, ncnt_d;
   logic [CW-1:0] gap_q, gap_d;
   logic [3:0]    d_q, d_d;
   logic          rs_q, rs_d;
   logic          e_q, e_d;

   logic          job_req;
   logic          job_rs;
   logic [3:0]    job_nib;
   logic [CW-1:0] job_gap;
   logic [7:0]    cur_byte;
   logic [7:0]    cfg_byte;
   logic          nib_start;
   logic          nib_done;
   logic [4:0]    radd_inc;

   assign nib_start = (nst_q == N_IDLE) && job_req;
   assign nib_done  = (nst_q == N_GAP) && (ncnt_q == gap_q - CW'(2));
   assign radd_inc  = radd_q + 5'd1;

   always_comb begin
      case (idx_q)
         2'd0:    cfg_byte = 8'h28;
         2'd1:    cfg_byte = 8'h06;
         2'd2:    cfg_byte = 8'h0C;
         default: cfg_byte = 8'h01;
      endcase
   end

   // Upper CHAR nibble comes straight from dout in the same cycle dout is captured.
   always_comb begin
      job_req  = (st_q != S_PWRUP);
      job_rs   = 1'b0;
      cur_byte = 8'h00;
      job_gap  = CW'(T_CMD);
      case (st_q)
         S_CFG:   cur_byte = cfg_byte;
         S_ADDR:  cur_byte = {1'b1, radd_q[4], 6'b000000};
         S_CHAR: begin
            cur_byte = lo_q ? char_q : dout;
            job_rs   = 1'b1;
         end
         default: cur_byte = 8'h00;
      endcase
      job_nib = lo_q ? cur_byte[3:0] : cur_byte[7:4];
      if (st_q == S_INIT) begin
         job_nib = (idx_q == 2'd3) ? 4'h2 : 4'h3;
         case (idx_q)
            2'd0:    job_gap = CW'(T_LONG);
            2'd1:    job_gap = CW'(T_SHORT);
            default: job_gap = CW'(T_CMD);
         endcase
      end else if (!lo_q) begin
         job_gap = CW'(E_CYC);
      end else if (!job_rs && cur_byte == 8'h01) begin
         job_gap = CW'(T_CLR);
      end
   end

   always_comb begin
      nst_d  = nst_q;
      ncnt_d = ncnt_q;
      gap_d  = gap_q;
      d_d    = d_q;
      rs_d   = rs_q;
      e_d    = e_q;
      case (nst_q)
         N_IDLE: begin
            if (job_req) begin
               nst_d  = N_SETUP;
               d_d    = job_nib;
               rs_d   = job_rs;
               gap_d  = job_gap;
               ncnt_d = '0;
            end
         end
         N_SETUP: begin
            nst_d  = N_EHI;
            e_d    = 1'b1;
            ncnt_d = '0;
         end
         N_EHI: begin
            if (ncnt_q == CW'(E_CYC - 1)) begin
               nst_d  = N_HOLD;
               e_d    = 1'b0;
               ncnt_d = '0;
            end else begin
               ncnt_d = ncnt_q + CW'(1);
            end
         end
         N_HOLD: begin
            nst_d  = N_GAP;
            ncnt_d = '0;
         end
         N_GAP: begin
            if (nib_done) begin
               nst_d  = N_IDLE;
               ncnt_d = '0;
            end else begin
               ncnt_d = ncnt_q + CW'(1);
            end
         end
         default: begin
            nst_d = N_IDLE;
            e_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      st_d    = st_q;
      pcnt_d  = pcnt_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      char_d  = char_q;
      radd_d  = radd_q;
      ready_d = ready_q;
      frame_d = 1'b0;
      if (st_q == S_PWRUP) begin
         if (pcnt_q == CW'(T_PWRUP - 1)) begin
            st_d   = S_INIT;
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + CW'(1);
         end
      end
      if (nib_start && st_q == S_CHAR && !lo_q)
         char_d = dout;
      if (nib_done) begin
         case (st_q)
            S_INIT: begin
               if (idx_q == 2'd3) begin
                  st_d  = S_CFG;
                  idx_d = 2'd0;
                  lo_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            S_CFG: begin
               lo_d = !lo_q;
               if (lo_q) begin
                  if (idx_q == 2'd3) begin
                     st_d    = S_ADDR;
                     idx_d   = 2'd0;
                     ready_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
            S_ADDR: begin
               lo_d = !lo_q;
               if (lo_q)
                  st_d = S_CHAR;
            end
            S_CHAR: begin
               lo_d = !lo_q;
               if (lo_q) begin
                  radd_d  = radd_inc;
                  frame_d = (radd_q == 5'd31);
                  if (radd_inc[3:0] == 4'd0)
                     st_d = S_ADDR;
               end
            end
            default: st_d = st_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= S_PWRUP;
         pcnt_q  <= '0;
         idx_q   <= 2'd0;
         lo_q    <= 1'b0;
         char_q  <= 8'h00;
         radd_q  <= 5'd0;
         ready_q <= 1'b0;
         frame_q <= 1'b0;
         nst_q   <= N_IDLE;
         ncnt_q  <= '0;
         gap_q   <= '0;
         d_q     <= 4'h0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         st_q    <= st_d;
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         char_q  <= char_d;
         radd_q  <= radd_d;
         ready_q <= ready_d;
         frame_q <= frame_d;
         nst_q   <= nst_d;
         ncnt_q  <= ncnt_d;
         gap_q   <= gap_d;
         d_q     <= d_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
      end
   end

   assign radd   = radd_q;
   assign lcd_d  = d_q;
   assign lcd_e  = e_q;
   assign lcd_rs = rs_q;
   assign lcd_rw = 1'b0;
   assign ready  = ready_q;
   assign frame  = frame_q;

endmodule

// File: tb/tb_lcd_refresh.sv
// Bench for lcd_refresh: a cycle timeline built from the LCD protocol rules is
// compared against the DUT every cycle, plus hand-computed pins and a protocol monitor.
module tb_lcd_refresh;

   localparam int TP   = 20;
   localparam int TL   = 10;
   localparam int TS   = 5;
   localparam int TC   = 4;
   localparam int TCLR = 8;
   localparam int EC   = 3;
   localparam int LEN  = 2600;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] radd;
   logic [7:0] dout;
   logic [3:0] lcd_d;
   logic       lcd_e, lcd_rs, lcd_rw, ready, frame;
   logic [7:0] ram [32];

   always #5 clk = ~clk;
   assign dout = ram[radd];

   lcd_refresh #(
      .T_PWRUP(TP), .T_LONG(TL), .T_SHORT(TS), .T_CMD(TC), .T_CLR(TCLR), .E_CYC(EC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .radd(radd), .dout(dout), .lcd_d(lcd_d),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .ready(ready), .frame(frame)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int nframes = 0;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected timeline, indexed by cycles since reset release
   logic       exp_e   [LEN];
   logic       exp_dv  [LEN];
   logic [3:0] exp_d   [LEN];
   logic       exp_rs  [LEN];
   logic       exp_rdy [LEN];
   logic       exp_frm [LEN];
   logic [4:0] exp_radd[LEN];
   int         wp;
   logic       m_rdy;
   logic [4:0] m_radd;

   task automatic put(input logic e, input logic dv, input logic [3:0] d, input logic rs,
                      input logic frm);
      if (wp < LEN) begin
         exp_e[wp]    = e;
         exp_dv[wp]   = dv;
         exp_d[wp]    = d;
         exp_rs[wp]   = rs;
         exp_rdy[wp]  = m_rdy;
         exp_frm[wp]  = frm;
         exp_radd[wp] = m_radd;
      end
      wp++;
   endtask

   // upd: 0 none, 1 ready rises, 2 character done (address advances)
   task automatic nib(input logic [3:0] d, input logic rs, input int gap, input int upd);
      logic frm;
      put(1'b0, 1'b1, d, rs, 1'b0);
      repeat (EC) put(1'b1, 1'b1, d, rs, 1'b0);
      put(1'b0, 1'b1, d, rs, 1'b0);
      for (int i = 0; i < gap; i++) begin
         frm = 1'b0;
         if (i == gap - 1) begin
            if (upd == 1) m_rdy = 1'b1;
            if (upd == 2) begin
               frm    = (m_radd == 5'd31);
               m_radd = m_radd + 5'd1;
            end
         end
         put(1'b0, 1'b0, 4'h0, 1'b0, frm);
      end
   endtask

   task automatic wbyte(input logic [7:0] b, input logic rs, input int upd);
      nib(b[7:4], rs, EC, 0);
      nib(b[3:0], rs, (!rs && b == 8'h01) ? TCLR : TC, upd);
   endtask

   function automatic logic [7:0] ram_model(input int a, input int f, input int run);
      if (a == 5) return (run == 1 && f == 0) ? 8'h46 : 8'h7A;
      return 8'(8'h41 + a);
   endfunction

   task automatic build(input int run);
      wp = 0;
      m_rdy = 1'b0;
      m_radd = 5'd0;
      repeat (TP + 1) put(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      nib(4'h3, 1'b0, TL, 0);
      nib(4'h3, 1'b0, TS, 0);
      nib(4'h3, 1'b0, TC, 0);
      nib(4'h2, 1'b0, TC, 0);
      wbyte(8'h28, 1'b0, 0);
      wbyte(8'h06, 1'b0, 0);
      wbyte(8'h0C, 1'b0, 0);
      wbyte(8'h01, 1'b0, 1);
      for (int f = 0; f < 4; f++)
         for (int a = 0; a < 32; a++) begin
            if (a == 0 || a == 16) wbyte((a == 0) ? 8'h80 : 8'hC0, 1'b0, 0);
            wbyte(ram_model(a, f, run), 1'b1, 2);
         end
   endtask

   // per-cycle model compare and protocol monitor
   logic       pv = 1'b0;
   logic       pe;
   logic [3:0] pd;
   logic       prs;
   logic [4:0] pradd;

   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (frame) nframes++;
         if (cyc < LEN) begin
            chk("lcd_e", 32'(lcd_e), 32'(exp_e[cyc]));
            if (exp_dv[cyc]) begin
               chk("lcd_d", 32'(lcd_d), 32'(exp_d[cyc]));
               chk("lcd_rs", 32'(lcd_rs), 32'(exp_rs[cyc]));
            end
            chk("ready", 32'(ready), 32'(exp_rdy[cyc]));
            chk("frame", 32'(frame), 32'(exp_frm[cyc]));
            chk("radd", 32'(radd), 32'(exp_radd[cyc]));
         end
         chk("lcd_rw", 32'(lcd_rw), 32'h0);
         if (pv && (lcd_e || pe)) begin
            chk("d_stable", 32'(lcd_d), 32'(pd));
            chk("rs_stable", 32'(lcd_rs), 32'(prs));
         end
         if (pv && lcd_e) chk("radd_stable", 32'(radd), 32'(pradd));
         pv = 1'b1;
         pe = lcd_e;
         pd = lcd_d;
         prs = lcd_rs;
         pradd = radd;
      end
   end

   task automatic wait_cyc(input int n);
      int g = 0;
      while (cyc < n && g < 5000) begin
         @(negedge clk);
         g++;
      end
      chk("wait_cyc", 32'(cyc), 32'(n));
   endtask

   task automatic release_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int g;
      for (int i = 0; i < 32; i++) ram[i] = 8'(8'h41 + i);
      build(1);
      release_reset();

      // reset state and hand-computed timeline pins
      chk("rst_e", 32'(lcd_e), 32'h0);
      chk("rst_radd", 32'(radd), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_d", 32'(lcd_d), 32'h0);
      wait_cyc(21); chk("pin21_e", 32'(lcd_e), 32'h0); chk("pin21_d", 32'(lcd_d), 32'h3);
      wait_cyc(22); chk("pin22_e", 32'(lcd_e), 32'h1);
      wait_cyc(25); chk("pin25_e", 32'(lcd_e), 32'h0);
      wait_cyc(36); chk("pin36_e", 32'(lcd_e), 32'h0);
      wait_cyc(37); chk("pin37_e", 32'(lcd_e), 32'h1);
      wait_cyc(134); chk("pin134_rdy", 32'(ready), 32'h0);
      wait_cyc(135); chk("pin135_rdy", 32'(ready), 32'h1);
      wait_cyc(137);
      chk("pin137_e", 32'(lcd_e), 32'h1);
      chk("pin137_d", 32'(lcd_d), 32'h8);
      chk("pin137_rs", 32'(lcd_rs), 32'h0);
      wait_cyc(154);
      chk("pin154_d", 32'(lcd_d), 32'h4);
      chk("pin154_rs", 32'(lcd_rs), 32'h1);

      // rewrite RAM[5] while its byte is being sent
      g = 0;
      while (!(radd == 5'd5 && lcd_e) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk("ram5_wait", 32'(g < 3000), 32'h1);
      ram[5] = 8'h7A;
      wait_cyc(247); chk("pin247_old", 32'(lcd_d), 32'h6);
      wait_cyc(712); chk("pin712_frm", 32'(frame), 32'h0);
      wait_cyc(713); chk("pin713_frm", 32'(frame), 32'h1); chk("pin713_radd", 32'(radd), 32'h0);
      wait_cyc(715); chk("pin715_d", 32'(lcd_d), 32'h8); chk("pin715_e", 32'(lcd_e), 32'h1);
      wait_cyc(825); chk("pin825_new", 32'(lcd_d), 32'hA);

      // reset in the middle of character 10's strobe, third frame
      g = 0;
      while (!(nframes >= 2 && radd == 5'd10 && lcd_e) && g < 5000) begin
         @(negedge clk);
         g++;
      end
      chk("mid_wait", 32'(g < 5000), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_e", 32'(lcd_e), 32'h0);
      chk("mid_radd", 32'(radd), 32'h0);
      chk("mid_ready", 32'(ready), 32'h0);
      chk("mid_frame", 32'(frame), 32'h0);
      build(2);
      release_reset();
      wait_cyc(21); chk("r2_21_e", 32'(lcd_e), 32'h0);
      wait_cyc(22); chk("r2_22_e", 32'(lcd_e), 32'h1); chk("r2_22_d", 32'(lcd_d), 32'h3);
      wait_cyc(135); chk("r2_135_rdy", 32'(ready), 32'h1);
      wait_cyc(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
